piece_queue_gen: RTL and testbench
==================================

// Module: piece_queue_gen
// PURPOSE
//  Generates the stream of falling tetrominoes consumed by the game core's spawn logic.
//  - Keeps a small FIFO of upcoming pieces, so the head piece is always ready when the core respawns.
//  - Refills from an LFSR-driven 7-bag randomiser.
//  - Exposes the head piece and its 4x4 spawn bitmap, plus the preview IDs for the display stage.
// PARAMETERS
//  DEPTH   3         queue slots incl. head; legal 1..4
//  SEED    16'hACE1  LFSR reset value; must be nonzero
// PORTS
//  clk           in   1        system clock; all state on posedge
//  rst           in   1        synchronous, active-high reset
//  take          in   1        1-cycle pop request (core spawned the head piece)
//  valid         out  1        queue non-empty; head outputs meaningful
//  piece_id      out  3        head piece ID 0..6; 3'd7 when empty
//  piece_shape   out  [0:15]   head 4x4 spawn bitmap, row-major, bit 0 = top-left
//  preview_id    out  3*DEPTH  slot k at [3k+2:3k]; slot 0 = head; empty slot = 3'd7
//  count         out  3        occupied slots, 0..DEPTH
// BEHAVIOUR
//  Reset (one clk with rst=1):
//   - lfsr<=SEED, queue emptied, count=0, valid=0, piece_id=7, piece_shape=0, preview_id all 7s, bag mask=0.
//   - rst overrides take and fill in the same cycle; mid-refill or mid-pop work is discarded.
//  LFSR:
//   - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1; steps every cycle incl. while full.
//   - Candidate c = lfsr[2:0] of the current cycle.
//  Accept rule (at most one accepted draw per cycle):
//   - c != 7, and !used[c] (bag), and space, where space = (count<DEPTH) | (take & valid).
//   - On accept, c is appended at tail slot (count - pop); visible on outputs next cycle.
//   - used |= 1<<c; if the result equals 7'h7F, used <= 0 instead (bag complete, new bag starts).
//   - Rejected candidates change nothing but the LFSR.
//  Pop:
//   - take & valid: slots shift toward head by one; next cycle head = old slot 1.
//   - take while !valid: ignored, not remembered.
//  Simultaneous pop+accept at full: count stays DEPTH; new piece enters slot DEPTH-1.
//  Count: count_next = count - pop + accept, never outside 0..DEPTH.
//  Latency:
//   - Outputs are registered.
//   - piece_shape is a combinational decode of registered piece_id (0-cycle).
//  Shape table (piece_shape for ID):
//   0 0100_0100_0100_0100  1 0000_0111_0100_0000  2 0000_1110_0010_0000
//   3 0000_1100_0110_0000  4 0000_0110_1100_0000  5 0000_1110_0100_0000
//   6 0000_0110_0110_0000  7 16'b0
//  Invariant: between bag completions no ID repeats; any 7 consecutive accepts after a bag boundary form a permutation of 0..6.
// CONFIGURATION
//  PIECE_BAG_EN defined:
//   - 7-bag rule above; used mask and completion logic present.
//  PIECE_BAG_EN undefined:
//   - bag mask removed; accept whenever c != 7 and space (uniform, repeats allowed).
//   - All other behaviour identical.
// TESTING
//  1. rst 1 cycle, then idle -> cycle after rst: valid=0, count=0, preview all 7; count rises to DEPTH and holds; valid=1.
//  2. BAG_EN, DEPTH=3: 7 takes spaced 20 cycles apart from reset -> popped IDs are a permutation of 0..6; next 7 also a permutation.
//  3. take at count=0 right after rst -> count unchanged, no underflow; first valid head is unaffected.
//  4. Full queue, take every cycle for 50 cycles -> count never exceeds DEPTH; each popped head equals the previous cycle's slot 1 ID.
//  5. Each head ID 0..6 -> piece_shape matches table, e.g. ID 6 -> 16'b0000_0110_0110_0000.
//  6. rst asserted together with take at full -> next cycle count=0, valid=0, lfsr=SEED; replayed sequence equals step 1's.

Source files
------------

// File: rtl/piece_queue_gen.sv
// Tetromino spawn queue: LFSR-fed randomiser refilling a DEPTH-slot FIFO, head decoded to a 4x4 bitmap.
// Optional feature macro PIECE_BAG_EN: 7-bag randomiser (no repeats within a bag); undefined = uniform draws.
module piece_queue_gen #(
  parameter int          DEPTH = 3,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               take,
  output logic               valid,
  output logic [2:0]         piece_id,
  output logic [0:15]        piece_shape,
  output logic [3*DEPTH-1:0] preview_id,
  output logic [2:0]         count
);
  localparam logic [2:0] DEPTH3 = 3'(DEPTH);

  logic [15:0]            r_lfsr;
  logic [DEPTH-1:0][2:0]  r_q;
  logic [2:0]             r_count;
  logic                   r_valid;

  logic                   w_fb;
  logic [2:0]             w_c;
  logic                   w_pop;
  logic                   w_space;
  logic                   w_acc;
  logic [2:0]             w_tail;
  logic [2:0]             w_cnt_nxt;
  logic [DEPTH-1:0][2:0]  w_q_nxt;

  assign w_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_c     = r_lfsr[2:0];
  assign w_pop   = take & r_valid;
  assign w_space = (r_count < DEPTH3) | w_pop;
  assign w_tail  = r_count - {2'b0, w_pop};

`ifdef PIECE_BAG_EN
  logic [6:0] r_used;
  logic [6:0] w_used_set;

  assign w_acc      = (w_c != 3'd7) && !r_used[w_c] && w_space;
  assign w_used_set = r_used | (7'd1 << w_c);

  always_ff @(posedge clk) begin
    if (rst)        r_used <= '0;
    else if (w_acc) r_used <= (w_used_set == 7'h7F) ? 7'h00 : w_used_set;
  end
`else
  assign w_acc = (w_c != 3'd7) && w_space;
`endif

  assign w_cnt_nxt = r_count - {2'b0, w_pop} + {2'b0, w_acc};

  // Empty slots always hold 7, so shifting a 7 into the last slot keeps that invariant.
  always_comb begin
    w_q_nxt = r_q;
    if (w_pop) begin
      for (int k = 0; k < DEPTH - 1; k++) w_q_nxt[k] = r_q[k+1];
      w_q_nxt[DEPTH-1] = 3'd7;
    end
    if (w_acc) begin
      for (int k = 0; k < DEPTH; k++)
        if (3'(k) == w_tail) w_q_nxt[k] = w_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr  <= SEED;
      r_q     <= {DEPTH{3'd7}};
      r_count <= 3'd0;
      r_valid <= 1'b0;
    end else begin
      r_lfsr  <= {w_fb, r_lfsr[15:1]};
      r_q     <= w_q_nxt;
      r_count <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != 3'd0);
    end
  end

  assign valid      = r_valid;
  assign count      = r_count;
  assign piece_id   = r_q[0];
  assign preview_id = r_q;

  // Literal's leftmost bit lands on index 0 (top-left) of the [0:15] vector.
  always_comb begin
    case (piece_id)
      3'd0:    piece_shape = 16'b0100_0100_0100_0100;
      3'd1:    piece_shape = 16'b0000_0111_0100_0000;
      3'd2:    piece_shape = 16'b0000_1110_0010_0000;
      3'd3:    piece_shape = 16'b0000_1100_0110_0000;
      3'd4:    piece_shape = 16'b0000_0110_1100_0000;
      3'd5:    piece_shape = 16'b0000_1110_0100_0000;
      3'd6:    piece_shape = 16'b0000_0110_0110_0000;
      default: piece_shape = 16'b0;
    endcase
  end
endmodule

// File: tb/tb_piece_queue_gen.sv
// Scoreboard bench for piece_queue_gen: reference model of LFSR/bag/queue, scenario tasks compare DUT state.
module tb_piece_queue_gen;
  localparam int          DEPTH = 3;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic               clk, rst, take;
  logic               valid;
  logic [2:0]         piece_id;
  logic [0:15]        piece_shape;
  logic [3*DEPTH-1:0] preview_id;
  logic [2:0]         count;

  piece_queue_gen #(.DEPTH(DEPTH), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .take(take), .valid(valid), .piece_id(piece_id),
    .piece_shape(piece_shape), .preview_id(preview_id), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  m_used;
  int          sbq[$];
  logic [3*DEPTH-1:0] rec1 [0:39];

  logic [15:0] shp [0:7] = '{16'b0100_0100_0100_0100, 16'b0000_0111_0100_0000,
                             16'b0000_1110_0010_0000, 16'b0000_1100_0110_0000,
                             16'b0000_0110_1100_0000, 16'b0000_1110_0100_0000,
                             16'b0000_0110_0110_0000, 16'b0};

  task automatic model(input logic r, input logic t);
    logic [2:0] c;
    bit acc;
    if (r) begin
      m_lfsr = SEED; sbq.delete(); m_used = '0;
      return;
    end
    c = m_lfsr[2:0];
    if (t && sbq.size() > 0) void'(sbq.pop_front());
    acc = (c != 3'd7) && (sbq.size() < DEPTH);
`ifdef PIECE_BAG_EN
    acc = acc && !m_used[c];
    if (acc) begin
      m_used = m_used | (8'd1 << c);
      if (m_used == 8'h7F) m_used = '0;
    end
`endif
    if (acc) sbq.push_back(int'(c));
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  function automatic logic [3*DEPTH-1:0] exp_prev();
    logic [3*DEPTH-1:0] v;
    v = '1;
    for (int k = 0; k < DEPTH; k++) if (k < sbq.size()) v[3*k +: 3] = 3'(sbq[k]);
    return v;
  endfunction

  task automatic step(input logic r, input logic t);
    @(negedge clk);
    rst = r; take = t;
    @(posedge clk);
    model(r, t);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 200 && count !== 3'(DEPTH); i++) step(1'b0, 1'b0);
    checks++;
    if (count !== 3'(DEPTH)) begin errs++; $display("FAIL fill_timeout count=%0d exp=%0d", count, DEPTH); end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0);
    checks++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (piece_id !== 3'd7) begin errs++; $display("FAIL reset_id got=%0d exp=7", piece_id); end
    checks++; if (piece_shape !== 16'b0) begin errs++; $display("FAIL reset_shape got=%h exp=0", piece_shape); end
    checks++;
    if (preview_id !== {DEPTH{3'd7}}) begin errs++; $display("FAIL reset_preview got=%h exp=%h", preview_id, {DEPTH{3'd7}}); end
  endtask

  task automatic test_fill();
    rec1[0] = preview_id;
    for (int i = 1; i < 40; i++) begin
      step(1'b0, 1'b0);
      rec1[i] = preview_id;
      checks++;
      if (preview_id !== exp_prev()) begin errs++; $display("FAIL fill_preview cyc=%0d got=%h exp=%h", i, preview_id, exp_prev()); end
      checks++;
      if (count !== 3'(sbq.size())) begin errs++; $display("FAIL fill_count cyc=%0d got=%0d exp=%0d", i, count, sbq.size()); end
    end
    fill();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (count !== 3'(DEPTH) || valid !== 1'b1) begin errs++; $display("FAIL full_hold count=%0d valid=%0b exp=%0d/1", count, valid, DEPTH); end
    end
  endtask

  task automatic test_take_empty();
    logic [2:0] first;
    first = 3'd7;
    for (int i = 39; i >= 0; i--) if (rec1[i][2:0] != 3'd7) first = rec1[i][2:0];
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if (count > 3'd1 || count !== 3'(sbq.size())) begin errs++; $display("FAIL empty_take_count got=%0d exp=%0d", count, sbq.size()); end
    for (int i = 0; i < 50 && valid !== 1'b1; i++) step(1'b0, 1'b0);
    checks++;
    if (valid !== 1'b1 || piece_id !== first) begin errs++; $display("FAIL empty_take_head got=%0d valid=%0b exp=%0d", piece_id, valid, first); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] prev1;
    logic [2:0] prevc;
    fill();
    for (int i = 0; i < 50; i++) begin
      prev1 = preview_id[5:3];
      prevc = count;
      step(1'b0, 1'b1);
      checks++;
      if (count > 3'(DEPTH) || count !== 3'(sbq.size())) begin errs++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", i, count, sbq.size()); end
      checks++;
      if (preview_id !== exp_prev()) begin errs++; $display("FAIL b2b_preview cyc=%0d got=%h exp=%h", i, preview_id, exp_prev()); end
      if (prevc >= 3'd2) begin
        checks++;
        if (piece_id !== prev1) begin errs++; $display("FAIL b2b_shift cyc=%0d got=%0d exp=%0d", i, piece_id, prev1); end
      end
    end
  endtask

`ifdef PIECE_BAG_EN
  task automatic test_bag();
    logic [6:0] mask;
    step(1'b1, 1'b0);
    for (int g = 0; g < 2; g++) begin
      mask = '0;
      for (int j = 0; j < 7; j++) begin
        repeat (20) step(1'b0, 1'b0);
        checks++;
        if (valid !== 1'b1 || piece_id === 3'd7 || piece_id !== 3'(sbq[0])) begin
          errs++; $display("FAIL bag_head grp=%0d n=%0d got=%0d valid=%0b exp=%0d", g, j, piece_id, valid, sbq[0]);
        end
        if (piece_id != 3'd7) mask = mask | (7'd1 << piece_id);
        step(1'b0, 1'b1);
      end
      checks++;
      if (mask !== 7'h7F) begin errs++; $display("FAIL bag_perm grp=%0d got=%h exp=7f", g, mask); end
    end
  endtask
`endif

  task automatic test_shapes();
    logic [7:0]  seen;
    logic [15:0] got;
    step(1'b1, 1'b0);
    seen = '0;
    for (int i = 0; i < 400 && seen[6:0] != 7'h7F; i++) begin
      step(1'b0, 1'(i % 2));
      if (valid === 1'b1) begin
        got = piece_shape;
        checks++;
        if (got !== shp[piece_id]) begin errs++; $display("FAIL shape id=%0d got=%b exp=%b", piece_id, got, shp[piece_id]); end
        seen[piece_id] = 1'b1;
      end
    end
    checks++;
    if (seen[6:0] !== 7'h7F) begin errs++; $display("FAIL shape_coverage got=%h exp=7f", seen[6:0]); end
  endtask

  task automatic test_reset_take();
    fill();
    step(1'b1, 1'b1);
    checks++;
    if (count !== 3'd0 || valid !== 1'b0) begin errs++; $display("FAIL rst_take count=%0d valid=%0b exp=0/0", count, valid); end
    checks++;
    if (preview_id !== rec1[0]) begin errs++; $display("FAIL rst_take_preview got=%h exp=%h", preview_id, rec1[0]); end
    for (int i = 1; i < 40; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (preview_id !== rec1[i]) begin errs++; $display("FAIL replay cyc=%0d got=%h exp=%h", i, preview_id, rec1[i]); end
    end
  endtask

  initial begin
    rst = 1'b0; take = 1'b0;
    test_reset();
    test_fill();
    test_take_empty();
    test_back_to_back();
`ifdef PIECE_BAG_EN
    test_bag();
`endif
    test_shapes();
    test_reset_take();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
